// File: rtl/mode_sequencer_alu.sv
// Switch-driven ALU front end with a debounced key that steps through arithmetic,
// logical, compare and timed accumulator/LED-scanner modes.
module mode_sequencer_alu #(
  parameter int W               = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TICK_CYCLES     = 12500000,
  parameter int LED_N           = 10
) (
  input  logic               MAX10_CLK1_50,
  input  logic               RESET_N,
  input  logic               KEY_N,
  input  logic [W-1:0]       X,
  input  logic [W-1:0]       Y,
  input  logic [1:0]         SEL,
  output logic [1:0]         MODE,
  output logic               MODE_CHANGED,
  output logic [2*W-1:0]     RESULT,
  output logic               FLAG,
  output logic [LED_N-1:0]   LEDR
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TICK_CYCLES + 1);
  localparam int PW = $clog2(LED_N);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] POS_TOP   = PW'(LED_N - 1);

  typedef enum logic [1:0] {
    M_ARITH = 2'd0,
    M_LOGIC = 2'd1,
    M_CMP   = 2'd2,
    M_ACC   = 2'd3
  } mode_t;

  mode_t            mode;
  logic             key_s1, key_s2, key_level;
  logic [DW-1:0]    deb_cnt;
  logic [TW-1:0]    tick_cnt, tick_nxt;
  logic [2*W-1:0]   acc, acc_nxt;
  logic             wrap, wrap_nxt;
  logic [PW-1:0]    scan_pos, pos_nxt;
  logic             scan_up, up_nxt;
  logic             press, tick;
  logic [2*W:0]     acc_sum;

  logic [W:0]       add_w;
  logic [W-1:0]     diff, neg;
  logic [2*W-1:0]   prod;
  logic             lt, gt, eq;
  logic [2*W-1:0]   calc_res, res_nxt;
  logic             calc_flag, flag_nxt;
  logic [LED_N-1:0] ledr_nxt;

  assign MODE  = mode;
  assign press = (key_s2 != key_level) && (deb_cnt == DEB_LAST) && !key_s2;

  // Combinational result for the stateless modes 0-2
  always_comb begin
    add_w     = {1'b0, X} + {1'b0, Y};
    diff      = X - Y;
    neg       = '0 - X;
    prod      = {{W{1'b0}}, X} * {{W{1'b0}}, Y};
    lt        = X < Y;
    gt        = X > Y;
    eq        = X == Y;
    calc_res  = '0;
    calc_flag = 1'b0;
    unique case (mode)
      M_ARITH: begin
        unique case (SEL)
          2'b00: begin calc_res = {{(W-1){1'b0}}, add_w};   calc_flag = add_w[W]; end
          2'b01: begin calc_res = {{W{lt}}, diff};          calc_flag = lt;       end
          2'b10: begin calc_res = prod;                     calc_flag = 1'b0;     end
          2'b11: begin calc_res = {{W{neg[W-1]}}, neg};     calc_flag = (X == '0); end
        endcase
      end
      M_LOGIC: begin
        unique case (SEL)
          2'b00: calc_res = {{W{1'b0}}, X & Y};
          2'b01: calc_res = {{W{1'b0}}, X | Y};
          2'b10: calc_res = {{W{1'b0}}, X ^ Y};
          2'b11: calc_res = {{W{1'b0}}, ~X};
        endcase
        calc_flag = (calc_res[W-1:0] == '0);
      end
      M_CMP: begin
        unique case (SEL)
          2'b00: calc_res = {{(2*W-1){1'b0}}, eq};
          2'b01: calc_res = {{(2*W-1){1'b0}}, gt};
          2'b10: calc_res = {{(2*W-1){1'b0}}, lt};
          2'b11: calc_res = {{W{1'b0}}, gt ? X : Y};
        endcase
        calc_flag = eq;
      end
      default: ;
    endcase
  end

  // Accumulator/scanner next state; a press always wins over a tick
  always_comb begin
    tick     = (mode == M_ACC) && !SEL[1] && (tick_cnt == TICK_LAST) && !press;
    acc_sum  = {1'b0, acc} + {{(W+1){1'b0}}, X};
    tick_nxt = tick_cnt;
    acc_nxt  = acc;
    wrap_nxt = wrap;
    pos_nxt  = scan_pos;
    up_nxt   = scan_up;
    if (press) begin
      tick_nxt = '0;
      acc_nxt  = '0;
      wrap_nxt = 1'b0;
      pos_nxt  = '0;
      up_nxt   = 1'b1;
    end else if (mode == M_ACC) begin
      if (!SEL[1]) tick_nxt = tick ? '0 : tick_cnt + TW'(1);
      if (tick) begin
        if (scan_up) begin
          if (scan_pos == POS_TOP) begin pos_nxt = scan_pos - PW'(1); up_nxt = 1'b0; end
          else pos_nxt = scan_pos + PW'(1);
        end else begin
          if (scan_pos == '0) begin pos_nxt = scan_pos + PW'(1); up_nxt = 1'b1; end
          else pos_nxt = scan_pos - PW'(1);
        end
      end
      if (SEL[0]) begin
        acc_nxt  = '0;
        wrap_nxt = 1'b0;
      end else if (tick) begin
        acc_nxt = acc_sum[2*W-1:0];
        if (acc_sum[2*W]) wrap_nxt = 1'b1;
      end
    end
  end

  // Outputs are registered from next-state values so they land on the same edge
  always_comb begin
    ledr_nxt = '0;
    if (mode == M_ACC) begin
      res_nxt           = acc_nxt;
      flag_nxt          = wrap_nxt;
      ledr_nxt[pos_nxt] = 1'b1;
    end else begin
      res_nxt  = calc_res;
      flag_nxt = calc_flag;
      if (mode == M_ARITH) ledr_nxt[LED_N-1] = calc_flag;
    end
  end

  always_ff @(posedge MAX10_CLK1_50) begin
    if (!RESET_N) begin
      key_s1       <= 1'b1;
      key_s2       <= 1'b1;
      key_level    <= 1'b1;
      deb_cnt      <= '0;
      mode         <= M_ARITH;
      MODE_CHANGED <= 1'b0;
      tick_cnt     <= '0;
      acc          <= '0;
      wrap         <= 1'b0;
      scan_pos     <= '0;
      scan_up      <= 1'b1;
      RESULT       <= '0;
      FLAG         <= 1'b0;
      LEDR         <= '0;
    end else begin
      key_s1 <= KEY_N;
      key_s2 <= key_s1;
      if (key_s2 == key_level) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        deb_cnt   <= '0;
        key_level <= key_s2;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      MODE_CHANGED <= press;
      if (press) mode <= mode_t'(mode + 2'd1);
      tick_cnt <= tick_nxt;
      acc      <= acc_nxt;
      wrap     <= wrap_nxt;
      scan_pos <= pos_nxt;
      scan_up  <= up_nxt;
      RESULT   <= res_nxt;
      FLAG     <= flag_nxt;
      LEDR     <= ledr_nxt;
    end
  end

endmodule

// File: tb/tb_mode_sequencer_alu.sv
// Self-checking bench for mode_sequencer_alu: vector table for the combinational
// modes plus hand-timed debounce and accumulator/scanner sequences.
module tb_mode_sequencer_alu;

  logic       clk = 1'b0;
  logic       rst_n, key_n;
  logic [3:0] x, y;
  logic [1:0] sel, mode;
  logic       mode_changed, flag;
  logic [7:0] result;
  logic [9:0] ledr;

  mode_sequencer_alu #(
    .W(4),
    .DEBOUNCE_CYCLES(4),
    .TICK_CYCLES(8),
    .LED_N(10)
  ) dut (
    .MAX10_CLK1_50(clk),
    .RESET_N(rst_n),
    .KEY_N(key_n),
    .X(x),
    .Y(y),
    .SEL(sel),
    .MODE(mode),
    .MODE_CHANGED(mode_changed),
    .RESULT(result),
    .FLAG(flag),
    .LEDR(ledr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] sel;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] res;
    logic       flg;
    logic [9:0] led;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] res;
    logic       flg;
    logic [9:0] led;
  } exp_t;

  vec_t vecs[21];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   pulses = 0;

  always @(negedge clk) if (mode_changed === 1'b1) pulses++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got no expectation, expected one queued");
    end else begin
      e = sb.pop_front();
      check({e.name, "_result"}, {24'd0, result}, {24'd0, e.res});
      check({e.name, "_flag"}, {31'd0, flag}, {31'd0, e.flg});
      check({e.name, "_ledr"}, {22'd0, ledr}, {22'd0, e.led});
    end
  endtask

  task automatic expect_after(input int cycles, input string name, input logic [7:0] res,
                              input logic flg, input logic [9:0] led);
    sb.push_back('{name, res, flg, led});
    repeat (cycles) @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      x   = vecs[i].x;
      y   = vecs[i].y;
      sel = vecs[i].sel;
      sb.push_back('{$sformatf("vec%0d", i), vecs[i].res, vecs[i].flg, vecs[i].led});
      @(posedge clk);
      #1;
      pop_check();
    end
  endtask

  task automatic press(input logic [1:0] exp_mode, input bit settle);
    bit got;
    got   = 1'b0;
    key_n = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (mode_changed === 1'b1) got = 1'b1;
    end
    checks++;
    if (got) passes++;
    else $display("FAIL press_timeout: got no MODE_CHANGED, expected a pulse within 20 cycles");
    check("press_mode", {30'd0, mode}, {30'd0, exp_mode});
    key_n = 1'b1;
    if (settle) begin
      repeat (12) @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0]  = '{2'b00, 4'd9,  4'd8,  8'h11, 1'b1, 10'h200};
    vecs[1]  = '{2'b01, 4'd3,  4'd5,  8'hFE, 1'b1, 10'h200};
    vecs[2]  = '{2'b10, 4'd15, 4'd15, 8'hE1, 1'b0, 10'h000};
    vecs[3]  = '{2'b11, 4'd3,  4'd0,  8'hFD, 1'b0, 10'h000};
    vecs[4]  = '{2'b11, 4'd0,  4'd0,  8'h00, 1'b1, 10'h200};
    vecs[5]  = '{2'b00, 4'd7,  4'd2,  8'h09, 1'b0, 10'h000};
    vecs[6]  = '{2'b01, 4'd5,  4'd3,  8'h02, 1'b0, 10'h000};
    vecs[7]  = '{2'b00, 4'd8,  4'd8,  8'h10, 1'b1, 10'h200};
    vecs[8]  = '{2'b00, 4'hC,  4'hA,  8'h08, 1'b0, 10'h000};
    vecs[9]  = '{2'b01, 4'hC,  4'hA,  8'h0E, 1'b0, 10'h000};
    vecs[10] = '{2'b10, 4'hC,  4'hA,  8'h06, 1'b0, 10'h000};
    vecs[11] = '{2'b11, 4'hC,  4'hA,  8'h03, 1'b0, 10'h000};
    vecs[12] = '{2'b00, 4'h5,  4'hA,  8'h00, 1'b1, 10'h000};
    vecs[13] = '{2'b11, 4'hF,  4'h0,  8'h00, 1'b1, 10'h000};
    vecs[14] = '{2'b11, 4'd7,  4'd7,  8'h07, 1'b1, 10'h000};
    vecs[15] = '{2'b00, 4'd7,  4'd7,  8'h01, 1'b1, 10'h000};
    vecs[16] = '{2'b01, 4'd9,  4'd4,  8'h01, 1'b0, 10'h000};
    vecs[17] = '{2'b10, 4'd9,  4'd4,  8'h00, 1'b0, 10'h000};
    vecs[18] = '{2'b11, 4'd4,  4'd9,  8'h09, 1'b0, 10'h000};
    vecs[19] = '{2'b10, 4'd4,  4'd9,  8'h01, 1'b0, 10'h000};
    vecs[20] = '{2'b10, 4'd6,  4'd7,  8'h2A, 1'b0, 10'h000};

    rst_n = 1'b0;
    key_n = 1'b1;
    x     = '0;
    y     = '0;
    sel   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_mode", {30'd0, mode}, 32'd0);
    check("reset_mode_changed", {31'd0, mode_changed}, 32'd0);
    sb.push_back('{"reset", 8'h00, 1'b0, 10'h000});
    pop_check();
    rst_n = 1'b1;

    run_vecs(0, 7);

    // short glitch must be rejected
    key_n = 1'b0;
    repeat (2) @(posedge clk);
    key_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("glitch_pulses", pulses, 0);
    check("glitch_mode", {30'd0, mode}, 32'd0);

    key_n = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("press_pulses", pulses, 1);
    check("press_mode1", {30'd0, mode}, 32'd1);
    repeat (100) @(posedge clk);
    #1;
    check("hold_pulses", pulses, 1);
    key_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("release_pulses", pulses, 1);
    check("release_mode", {30'd0, mode}, 32'd1);

    run_vecs(8, 13);
    press(2'd2, 1'b1);
    run_vecs(14, 19);

    // accumulator: entry edge is the one that raised MODE_CHANGED
    x   = 4'd15;
    sel = 2'b00;
    press(2'd3, 1'b0);
    expect_after(1,  "m3_entry",  8'h00, 1'b0, 10'h001);
    expect_after(71, "m3_tick9",  8'h87, 1'b0, 10'h200);
    expect_after(64, "m3_tick17", 8'hFF, 1'b0, 10'h002);
    expect_after(8,  "m3_tick18", 8'h0E, 1'b1, 10'h001);
    expect_after(7,  "m3_pre19",  8'h0E, 1'b1, 10'h001);
    expect_after(1,  "m3_tick19", 8'h1D, 1'b1, 10'h002);
    sel = 2'b10;
    expect_after(30, "m3_pause",  8'h1D, 1'b1, 10'h002);
    sel = 2'b01;
    expect_after(1,  "m3_clear",  8'h00, 1'b0, 10'h002);
    sel = 2'b00;

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midreset_mode", {30'd0, mode}, 32'd0);
    sb.push_back('{"midreset", 8'h00, 1'b0, 10'h000});
    pop_check();
    rst_n = 1'b1;

    press(2'd1, 1'b1);
    press(2'd2, 1'b1);
    press(2'd3, 1'b1);
    press(2'd0, 1'b1);
    check("total_pulses", pulses, 7);
    run_vecs(20, 20);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
